// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle control FSM:
//   - state_e      : FSM state encoding (IF=0, ID=1, EX=2, MEM=3, WB=4)
//   - inst_class_e : instruction classes produced by the decoder
//   - OP_* / FN_*  : opcode and function-field constants
//   - is_jump()    : classes that redirect the PC during ID
// -----------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    CLS_RTYPE   = 4'd0,
    CLS_JR      = 4'd1,
    CLS_IMM     = 4'd2,
    CLS_LW      = 4'd3,
    CLS_SW      = 4'd4,
    CLS_BEQ     = 4'd5,
    CLS_J       = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_ILLEGAL = 4'd8
  } inst_class_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function fields (op == OP_RTYPE)
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Classes whose PC update happens in ID.
  function automatic logic is_jump(inst_class_e c);
    return (c == CLS_J) || (c == CLS_JAL) || (c == CLS_JR);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Bundle between the control FSM and the datapath.
//   Datapath -> FSM : op[5:0], funct[5:0], zero, mem_ready
//   FSM -> datapath : pc_we, ir_we, ab_we, rf_we, dm_we, dm_re
// Handshake: there is no valid/ready pairing here. Every enable is a
// level that is meaningful for exactly the cycle it is high and is acted on
// at the following rising clk edge. mem_ready is a level from memory that
// marks the cycle in which the current IF or MEM access completes.
// Modports:
//   master : the control FSM (drives the enables)
//   slave  : the datapath (drives the instruction fields and flags)
// -----------------------------------------------------------------------------
interface mc_ctrl_fsm_if;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_we;
  logic       ir_we;
  logic       ab_we;
  logic       rf_we;
  logic       dm_we;
  logic       dm_re;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_we, ir_we, ab_we, rf_we, dm_we, dm_re
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_we, ir_we, ab_we, rf_we, dm_we, dm_re
  );

endinterface

// File: rtl/mc_inst_class.sv
// -----------------------------------------------------------------------------
// mc_inst_class
// Purely combinational op/funct -> instruction-class decoder.
// Ports:
//   op    [5:0] : opcode field
//   funct [5:0] : function field (only used when op == 0)
//   cls         : decoded class; anything unrecognised is CLS_ILLEGAL
// -----------------------------------------------------------------------------
module mc_inst_class
  import mc_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output inst_class_e cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: cls = CLS_RTYPE;
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: cls = CLS_IMM;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle processor control FSM (IF -> ID -> EX -> MEM -> WB subsets).
// Parameters:
//   CNT_W     : width of the retired-instruction counter (default 32)
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : mc_ctrl_fsm_if.master (op/funct/zero/mem_ready in,
//               pc_we/ir_we/ab_we/rf_we/dm_we/dm_re out)
//   state     : current FSM state (debug view of the state register)
//   illegal   : one-cycle pulse when an unrecognised instruction is in ID
//   retire    : one-cycle pulse in the last cycle of each legal instruction
//   instr_cnt : retired-instruction count, wraps at 2^CNT_W
// Build option:
//   MC_CTRL_MEMWAIT_EN : when defined, IF and MEM stall until mem_ready=1;
//                        otherwise mem_ready is ignored and both take one
//                        cycle.
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  mc_ctrl_fsm_if.master    bus,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt
);

  import mc_pkg::*;

  state_e           state_q, state_d;
  inst_class_e      cls_q, cls_d;
  inst_class_e      dec_cls;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_done;

  // Ungated enables; the rst gate at the bottom forces everything low
  // combinationally the moment reset is applied.
  logic pc_we_c, ir_we_c, ab_we_c, rf_we_c, dm_we_c, dm_re_c;
  logic illegal_c, retire_c;

  mc_inst_class u_inst_class (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (dec_cls)
  );

`ifdef MC_CTRL_MEMWAIT_EN
  assign mem_done = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_done         = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IF;
      cls_q   <= CLS_ILLEGAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = cnt_q;
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    ab_we_c   = 1'b0;
    rf_we_c   = 1'b0;
    dm_we_c   = 1'b0;
    dm_re_c   = 1'b0;
    illegal_c = 1'b0;
    retire_c  = 1'b0;

    case (state_q)
      ST_IF: begin
        if (mem_done) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = ST_ID;
        end
      end

      ST_ID: begin
        // Class is captured here so later op/funct changes cannot steer
        // the rest of this instruction.
        cls_d = dec_cls;
        if (dec_cls == CLS_ILLEGAL) begin
          illegal_c = 1'b1;
          state_d   = ST_IF;
        end else begin
          ab_we_c = 1'b1;
          pc_we_c = is_jump(dec_cls);
          case (dec_cls)
            CLS_J, CLS_JR: begin
              retire_c = 1'b1;
              state_d  = ST_IF;
            end
            CLS_JAL: state_d = ST_WB;
            default: state_d = ST_EX;
          endcase
        end
      end

      ST_EX: begin
        case (cls_q)
          CLS_RTYPE, CLS_IMM: state_d = ST_WB;
          CLS_LW, CLS_SW:     state_d = ST_MEM;
          CLS_BEQ: begin
            pc_we_c  = bus.zero;
            retire_c = 1'b1;
            state_d  = ST_IF;
          end
          default: state_d = ST_IF;
        endcase
      end

      ST_MEM: begin
        dm_re_c = (cls_q == CLS_LW);
        if (mem_done) begin
          if (cls_q == CLS_LW) begin
            state_d = ST_WB;
          end else begin
            dm_we_c  = (cls_q == CLS_SW);
            retire_c = (cls_q == CLS_SW);
            state_d  = ST_IF;
          end
        end
      end

      ST_WB: begin
        rf_we_c  = 1'b1;
        retire_c = 1'b1;
        state_d  = ST_IF;
      end

      default: state_d = ST_IF;
    endcase

    if (retire_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_we = pc_we_c & ~rst;
  assign bus.ir_we = ir_we_c & ~rst;
  assign bus.ab_we = ab_we_c & ~rst;
  assign bus.rf_we = rf_we_c & ~rst;
  assign bus.dm_we = dm_we_c & ~rst;
  assign bus.dm_re = dm_re_c & ~rst;
  assign illegal   = illegal_c & ~rst;
  assign retire    = retire_c & ~rst;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Self-checking bench for mc_ctrl_fsm (CNT_W=4 so the counter wraps quickly).
// The driver expands each instruction into its per-cycle expected outputs
// from the class -> state-sequence table and pushes them to exp_q; the
// negedge monitor pops and compares whenever an expectation is pending.
// Works in both builds (MC_CTRL_MEMWAIT_EN defined or not).
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  localparam int CNT_W = 4;
  localparam int W     = 3 + 6 + 2 + CNT_W;

  // Reference classes
  localparam int C_RT  = 0;
  localparam int C_JR  = 1;
  localparam int C_IMM = 2;
  localparam int C_LW  = 3;
  localparam int C_SW  = 4;
  localparam int C_BEQ = 5;
  localparam int C_J   = 6;
  localparam int C_JAL = 7;
  localparam int C_ILL = 8;

  // Phase numbers double as the architectural state numbers.
  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if bus ();
  logic [2:0]       state;
  logic             illegal;
  logic             retire;
  logic [CNT_W-1:0] instr_cnt;

  mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state     (state),
    .illegal   (illegal),
    .retire    (retire),
    .instr_cnt (instr_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] model_cnt;
  int               checks;
  int               failures;

  logic [11:0] legal_tab [17] = '{
    {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h24},
    {6'h00, 6'h25}, {6'h00, 6'h2A}, {6'h00, 6'h08}, {6'h08, 6'h00},
    {6'h09, 6'h11}, {6'h0C, 6'h22}, {6'h0D, 6'h33}, {6'h0F, 6'h3F},
    {6'h23, 6'h05}, {6'h2B, 6'h06}, {6'h04, 6'h07}, {6'h02, 6'h09},
    {6'h03, 6'h0A}
  };

  function automatic int ref_class(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      if (f == 6'h20 || f == 6'h21 || f == 6'h23 || f == 6'h24 ||
          f == 6'h25 || f == 6'h2A) return C_RT;
      if (f == 6'h08) return C_JR;
      return C_ILL;
    end
    if (o == 6'h08 || o == 6'h09 || o == 6'h0C || o == 6'h0D || o == 6'h0F)
      return C_IMM;
    case (o)
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h02:   return C_J;
      6'h03:   return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, bus.pc_we, bus.ir_we, bus.ab_we, bus.rf_we, bus.dm_we,
           bus.dm_re, illegal, retire, instr_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL trace t=%0t act st=%0d en(pc,ir,ab,rf,dmw,dmr)=%b ill=%b ret=%b cnt=%0d exp st=%0d en=%b ill=%b ret=%b cnt=%0d",
                 $time, a[W-1:W-3], a[W-4:W-9], a[W-10], a[W-11], a[CNT_W-1:0],
                 e[W-1:W-3], e[W-4:W-9], e[W-10], e[W-11], e[CNT_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Runs one instruction from its IF cycle. Entered and left at posedge+1.
  // if_wait/mem_wait: cycles with mem_ready low before the access completes
  // (only meaningful when the wait option is built in). max_cyc < 0 runs
  // the whole instruction; otherwise only the first max_cyc cycles.
  task automatic drive_instr(input logic [5:0] op_v, input logic [5:0] fn_v,
                             input logic zero_v, input int if_wait,
                             input int mem_wait, input int max_cyc,
                             input bit rand_rdy);
    int   cls;
    bit   legal;
    bit   jmp;
    int   ph[$];
    int   ncyc;
    int   nw;
    logic rdy, done, last;
    logic e_pc, e_ir, e_ab, e_rf, e_dmw, e_dmr, e_ill, e_ret;

    cls   = ref_class(op_v, fn_v);
    legal = (cls != C_ILL);
    jmp   = (cls == C_J) || (cls == C_JAL) || (cls == C_JR);
    ph.delete();
    ph.push_back(P_IF);
    ph.push_back(P_ID);
    case (cls)
      C_RT, C_IMM: begin ph.push_back(P_EX); ph.push_back(P_WB); end
      C_LW:  begin ph.push_back(P_EX); ph.push_back(P_MEM); ph.push_back(P_WB); end
      C_SW:  begin ph.push_back(P_EX); ph.push_back(P_MEM); end
      C_BEQ: ph.push_back(P_EX);
      C_JAL: ph.push_back(P_WB);
      default: ;
    endcase

    ncyc = 0;
    for (int i = 0; i < ph.size(); i++) begin
      nw = 0;
`ifdef MC_CTRL_MEMWAIT_EN
      if (ph[i] == P_IF)  nw = if_wait;
      if (ph[i] == P_MEM) nw = mem_wait;
`endif
      for (int w = 0; w <= nw; w++) begin
        if (ncyc == max_cyc) return;
        done = (w == nw);
        last = done && (i == ph.size() - 1);
`ifdef MC_CTRL_MEMWAIT_EN
        if (ph[i] == P_IF || ph[i] == P_MEM) rdy = done;
        else rdy = 1'($urandom_range(0, 1));
`else
        rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
`endif
        e_pc  = (ph[i] == P_IF && done) || (ph[i] == P_ID && legal && jmp) ||
                (ph[i] == P_EX && cls == C_BEQ && zero_v);
        e_ir  = (ph[i] == P_IF && done);
        e_ab  = (ph[i] == P_ID && legal);
        e_rf  = (ph[i] == P_WB);
        e_dmw = (ph[i] == P_MEM && cls == C_SW && done);
        e_dmr = (ph[i] == P_MEM && cls == C_LW);
        e_ill = (ph[i] == P_ID && !legal);
        e_ret = last && legal;
        exp_q.push_back({3'(ph[i]), e_pc, e_ir, e_ab, e_rf, e_dmw, e_dmr,
                         e_ill, e_ret, model_cnt});
        if (e_ret) model_cnt = model_cnt + 1'b1;

        bus.op        = (ph[i] == P_ID) ? op_v : 6'($urandom_range(0, 63));
        bus.funct     = (ph[i] == P_ID) ? fn_v : 6'($urandom_range(0, 63));
        bus.zero      = (ph[i] == P_EX) ? zero_v : 1'($urandom_range(0, 1));
        bus.mem_ready = rdy;
        @(posedge clk);
        #1;
        ncyc++;
      end
    end
  endtask

  task automatic rand_instr(input bit legal_only);
    logic [11:0] e;
    logic [5:0]  o, f;
    if (legal_only || $urandom_range(0, 3) != 0) begin
      e = legal_tab[$urandom_range(0, 16)];
      o = e[11:6];
      f = e[5:0];
    end else begin
      o = 6'($urandom_range(0, 63));
      f = 6'($urandom_range(0, 63));
    end
    drive_instr(o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                $urandom_range(0, 2), -1, 1'b1);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.op        = 6'h00;
    bus.funct     = 6'h21;
    bus.zero      = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state",   32'(state), 32'd0);
    check("rst_enables", 32'({bus.pc_we, bus.ir_we, bus.ab_we, bus.rf_we,
                              bus.dm_we, bus.dm_re}), 32'd0);
    check("rst_pulses",  32'({illegal, retire}), 32'd0);
    check("rst_cnt",     32'(instr_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    model_cnt = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks    = 0;
    failures  = 0;
    model_cnt = '0;
    rst       = 1'b1;
    do_reset();

    // addu with mem_ready=1: 0,1,2,4 then back to IF with count 1
    drive_instr(6'h00, 6'h21, 1'b0, 0, 0, -1, 1'b0);
    check("addu_cnt",   32'(instr_cnt), 32'd1);
    check("addu_state", 32'(state), 32'd0);

    // lw with three stalled MEM cycles
    drive_instr(6'h23, 6'h00, 1'b0, 0, 3, -1, 1'b0);

    // beq taken then not taken
    drive_instr(6'h04, 6'h00, 1'b1, 0, 0, -1, 1'b1);
    drive_instr(6'h04, 6'h00, 1'b0, 0, 0, -1, 1'b1);

    // jal, then an illegal opcode
    drive_instr(6'h03, 6'h00, 1'b0, 0, 0, -1, 1'b1);
    drive_instr(6'h3F, 6'h15, 1'b0, 0, 0, -1, 1'b1);
    check("illegal_cnt", 32'(instr_cnt), 32'(model_cnt));

    // random mix including illegal encodings and memory stalls
    for (int n = 0; n < 40; n++) rand_instr(1'b0);

    // counter wrap: 16 retires from reset lands back on 0
    do_reset();
    for (int n = 0; n < 16; n++) rand_instr(1'b1);
    check("wrap_cnt", 32'(instr_cnt), 32'd0);

    // reset in the MEM cycle of sw
    rand_instr(1'b1);
    rand_instr(1'b1);
    drive_instr(6'h2B, 6'h00, 1'b0, 0, 0, 3, 1'b0);
    bus.op        = 6'h2B;
    bus.mem_ready = 1'b1;
    #2;
    check("sw_mem_state", 32'(state), 32'd3);
    check("sw_mem_dmwe",  32'(bus.dm_we), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_state",  32'(state), 32'd0);
    check("midrst_dmwe",   32'(bus.dm_we), 32'd0);
    check("midrst_retire", 32'(retire), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_cnt",     32'(instr_cnt), 32'd0);
    check("midrst_retire2", 32'(retire), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    model_cnt = '0;

    // fresh instruction after reset release
    drive_instr(6'h00, 6'h20, 1'b0, 0, 0, -1, 1'b0);
    check("post_rst_cnt", 32'(instr_cnt), 32'd1);

    repeat (2) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports op and funct, each input, 6 bits: the opcode and function fields from the instruction register.
REQ-005 The block SHALL have port zero, input, 1 bit: the ALU zero flag, sampled in EX for beq.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: the memory access-complete flag for IF and MEM.
REQ-007 The block SHALL have write-enable outputs pc_we, ir_we, ab_we, rf_we and dm_we, each 1 bit, enabling the PC, IR, A/B operand registers, register file and data memory respectively.
REQ-008 The block SHALL have output dm_re, 1 bit: the data-memory read strobe.
REQ-009 The block SHALL have outputs state (3 bits, current state), illegal (1-bit pulse), retire (1-bit pulse) and instr_cnt (CNT_W bits, number of retired instructions).

Function
REQ-010 The state encoding SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4; values 5-7 SHALL go to IF on the next edge.
REQ-011 Decode SHALL classify instructions as:
- RTYPE: op 0 with funct add, addu, subu, and, or or slt.
- JR: op 0 with funct 0x08.
- IMM: addi, addiu, andi, ori, lui.
- LW, SW, BEQ, J, JAL.
- ILLEGAL: anything else.
REQ-012 State sequences SHALL be:
- RTYPE and IMM: IF-ID-EX-WB.
- LW: IF-ID-EX-MEM-WB.
- SW: IF-ID-EX-MEM.
- BEQ: IF-ID-EX.
- J and JR: IF-ID.
- JAL: IF-ID-WB.
- After the final state of each sequence, the FSM returns to IF.
REQ-013 In IF, ir_we and pc_we SHALL be 1 only in the cycle that IF completes.
REQ-014 In ID, ab_we SHALL be 1; for J, JAL and JR, pc_we SHALL also be 1.
REQ-015 In EX for BEQ, pc_we SHALL equal zero.
REQ-016 In MEM, dm_re SHALL be 1 for LW; for SW, dm_we SHALL be 1 only in the cycle MEM completes.
REQ-017 In WB, rf_we SHALL be 1.
REQ-018 Every enable not listed for the current state and class SHALL be 0 (Moore outputs, plus gating by zero and mem_ready only).
REQ-019 retire SHALL pulse 1 in the final cycle of each legal instruction, and instr_cnt SHALL increment on that edge, wrapping from 2^CNT_W-1 to 0.
REQ-020 An ILLEGAL opcode in ID SHALL:
- pulse illegal for one cycle;
- assert no writes and no retire;
- return the FSM to IF.
REQ-021 An instruction's class SHALL be latched in ID and held until it returns to IF, independent of later op/funct changes.

Reset
REQ-022 While rst=1 the block SHALL hold state=IF, with all enables, illegal, retire and instr_cnt at 0, and rst SHALL take effect immediately regardless of current state.
REQ-023 Reset mid-instruction SHALL discard that instruction, with no retire pulse and no further writes.
REQ-024 After rst deasserts, the first edge SHALL begin a fresh IF.

Configuration
REQ-025 With MC_CTRL_MEMWAIT_EN defined, IF and MEM SHALL hold while mem_ready=0 and complete in the first cycle mem_ready=1, with dm_re held high throughout an LW MEM.
REQ-026 Without MC_CTRL_MEMWAIT_EN, mem_ready SHALL be ignored and IF and MEM SHALL always complete in one cycle.

Structure
REQ-027 The state encodings, the instruction-class enumeration and the opcode/funct constants SHALL live in shared package mc_pkg.
REQ-028 The op/funct-to-class decode SHALL be one combinational sub-module, mc_inst_class.

Verification
REQ-029 Bench: reset, then addu (op 0, funct 0x21) with mem_ready=1 -> states 0,1,2,4,0; rf_we high only in the WB cycle; instr_cnt=1.
REQ-030 Bench: lw (op 0x23) with MC_CTRL_MEMWAIT_EN defined and mem_ready low for 3 MEM cycles -> MEM lasts 4 cycles, dm_re high for all 4, retire in WB, 8 cycles total.
REQ-031 Bench: beq (op 0x04) with zero=1, then beq with zero=0 -> pc_we=1 in the first EX and 0 in the second; both take 3 cycles and retire.
REQ-032 Bench: jal (op 0x03) -> pc_we in ID, rf_we in WB, 3 cycles total; then op 0x3F -> illegal pulses once, no enables, instr_cnt unchanged.
REQ-033 Bench: rst asserted mid-cycle during the MEM of sw -> state=0 and dm_we=0 immediately, no retire pulse, instr_cnt=0.
REQ-034 Bench: CNT_W=4, retire 16 instructions -> instr_cnt wraps 15->0.
